// File: rtl/aplicador_up_if.sv
// Count-memory / field-register bus of aplicador_up: the memory read/erase port,
// the field register port and the start/busy/done handshake.
interface aplicador_up_if;
    logic       start;
    logic [7:0] dato_up;
    logic [7:0] fld_rd;
    logic [3:0] addrm;
    logic       erase;
    logic [3:0] fld_addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;

    modport master (
        input  start, dato_up, fld_rd,
        output addrm, erase, fld_addr, wr_en, wr_data, busy, done
    );

    modport slave (
        output start, dato_up, fld_rd,
        input  addrm, erase, fld_addr, wr_en, wr_data, busy, done
    );
endinterface

// File: rtl/aplicador_up.sv
// Applies pending RTC adjustment counts to BCD field registers, one field per pass.
// Optional macro APLICADOR_SKIP_ZERO_EN: zero-count fields skip the write and erase.
module aplicador_up #(
    parameter int NFIELDS = 9
) (
    input  logic           clk,
    input  logic           reset,
    aplicador_up_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_INC  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_ER   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [3:0] LAST = 4'(NFIELDS - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] n_q, n_d;
    logic [7:0] w_q, w_d;

    function automatic logic [7:0] fld_min(input logic [3:0] f);
        return (f == 4'd3 || f == 4'd4) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] fld_max(input logic [3:0] f);
        case (f)
            4'd0, 4'd1, 4'd6, 4'd7: return 8'h59;
            4'd2, 4'd8:             return 8'h23;
            4'd3:                   return 8'h31;
            4'd4:                   return 8'h12;
            default:                return 8'h99;
        endcase
    endfunction

    // Non-BCD or below-minimum contents restart from the field minimum.
    function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [3:0] f);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < fld_min(f))
            return fld_min(f);
        return v;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] f);
        logic [7:0] r;
        if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        if (r > fld_max(f))
            r = fld_min(f);
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        w_d     = w_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RD;
                    idx_d   = 4'd0;
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                n_d = bus.dato_up;
                w_d = sanitize(bus.fld_rd, idx_q);
                if (bus.dato_up != 8'd0) begin
                    state_d = S_INC;
                end else begin
`ifdef APLICADOR_SKIP_ZERO_EN
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_RD;
                    end
`else
                    state_d = S_WR;
`endif
                end
            end
            S_INC: begin
                w_d = bcd_inc(w_q, idx_q);
                n_d = n_q - 8'd1;
                if (n_q == 8'd1)
                    state_d = S_WR;
            end
            S_WR: state_d = S_ER;
            S_ER: begin
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            n_q     <= 8'd0;
            w_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            w_q     <= w_d;
        end
    end

    // Memory and field register share one address; it is held for the whole field pass.
    assign bus.addrm    = idx_q;
    assign bus.fld_addr = idx_q;
    assign bus.erase    = (state_q == S_ER);
    assign bus.wr_en    = (state_q == S_WR);
    assign bus.wr_data  = w_q;
    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done     = (state_q == S_DONE);
endmodule

// File: doc/aplicador_up.md
# aplicador_up

Downstream consumer of the 16×8 RTC adjustment-count memory. On `start` it sweeps the field addresses and, for each field:
- reads the pending increment count through `addrm`/`dato_up`;
- adds that count to the current BCD value of the matching RTC/timer field, with per-field wrap-around;
- writes the result to the field register file;
- clears the count through `erase`.

It sits between the count memory and the RTC field registers that are later pushed to the RTC chip.

## Interface
- `NFIELDS`, 9: number of fields swept, addresses 0..NFIELDS-1 (legal range 1..9).
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a sweep; sampled only in IDLE.
- `dato_up` in 8: count read from the memory, registered by the memory one cycle after `addrm`.
- `fld_rd` in 8: current BCD value of the field at `fld_addr` (combinational read).
- `addrm` out 4: memory read/erase address.
- `erase` out 1: one-cycle clear of `mem[addrm]`.
- `fld_addr` out 4: field register address; always equals `addrm`.
- `wr_en` out 1: one-cycle field write strobe.
- `wr_data` out 8: BCD value written when `wr_en`=1.
- `busy` out 1: high from first RD cycle to last ER cycle; upstream must hold `up` low while busy.
- `done` out 1: one-cycle pulse after the last field.

## Operation
- Field limits (BCD), as field: min..max:
  - 0 sec: 00..59
  - 1 min: 00..59
  - 2 hour: 00..23
  - 3 day: 01..31
  - 4 month: 01..12
  - 5 year: 00..99
  - 6 timer sec: 00..59
  - 7 timer min: 00..59
  - 8 timer hour: 00..23
- States: IDLE, RD, CAP, INC, WR, ER, DONE.
- IDLE: `start`=1 → RD with index i=0.
- RD: drive `addrm`=i → CAP.
- CAP: capture `dato_up` into an 8-bit down-counter n and `fld_rd` into an 8-bit work register w → INC if n≠0, else WR.
- INC: each cycle apply one BCD increment to w and decrement n; leave when n reaches 0 → WR.
- BCD increment:
  - low nibble 9→0 with carry into high nibble;
  - if the result exceeds the field max, w = field min.
- Invalid captured value (either nibble >9, or below field min) is replaced by field min before incrementing.
- WR: `wr_en`=1, `wr_data`=w → ER.
- ER: `erase`=1 with `addrm`=i.
  - If i=NFIELDS-1 → DONE; else i+1 → RD.
- DONE: `done`=1 for one cycle → IDLE.
- `start` while not IDLE is ignored; it is not queued.
- Increments landing on address i between CAP and ER are lost. This is a system rule: upstream is gated by `busy`.

## Timing
- Reset values: `addrm`=0, `fld_addr`=0, `erase`=0, `wr_en`=0, `wr_data`=0, `busy`=0, `done`=0, state IDLE, i=0, n=0, w=0.
- Reset mid-sweep aborts immediately to IDLE. Fields already written stay written; unprocessed counts stay in memory.
- Latency:
  - first RD is the cycle after `start` is sampled;
  - per field 4+n cycles (RD, CAP, n×INC, WR, ER);
  - `done` appears the cycle after the final ER.
- `wr_en` and `erase` are each exactly one cycle per field, never high simultaneously, and never high outside busy.
- Maximum sweep: NFIELDS×259 + 1 cycles.

## Configuration
- `APLICADOR_SKIP_ZERO_EN`:
  - Defined: CAP with n=0 goes directly to the next RD (or DONE after the last field). WR and ER are skipped, giving 2 cycles per zero-count field with no `wr_en` and no `erase`.
  - Undefined: every field runs WR and ER even when n=0. The field is rewritten with its own (sanitised) value.

## Test plan
- Reset with `start`=1 held → all outputs 0 and no `busy` until `reset` falls and `start` is sampled.
- Field 0 count 3, `fld_rd`=8'h58 → `wr_data`=8'h01 with `fld_addr`=0, then `erase` at `addrm`=0; field cycle count 7.
- Field 3 count 1, `fld_rd`=8'h31 → 8'h01. Field 4 count 13, `fld_rd`=8'h12 → 8'h01.
- Field 2 count 255, `fld_rd`=8'h00 → 8'h15 after 255 INC cycles; field total 259 cycles.
- Invalid input: field 0 `fld_rd`=8'h7A, count 2 → 8'h02. Second `start` pulsed mid-sweep → ignored, exactly one `done`.
- All counts 0, NFIELDS=9:
  - macro off → 9 `wr_en`, 9 `erase`, `done` 37 cycles after the first RD;
  - macro on → no `wr_en`/`erase`, `done` 19 cycles after the first RD.
